// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry and the feeder FSM state type.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_DONE = 2'd2
  } tx_state_t;

  localparam int unsigned CLKS_PER_BIT = 434;
  // start, 8 data, parity, stop
  localparam int unsigned FRAME_BITS   = 11;
  // One frame plus one spare bit time, doubled for margin (10416 cycles).
  localparam int unsigned TIMEOUT_DEFAULT = CLKS_PER_BIT * (FRAME_BITS + 1) * 2;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous byte FIFO with separate occupancy counter and overflow pulse.
module sync_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // Storage write; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, occupancy and overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push & full;
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Queues bytes and hands them to the UART transmitter one at a time,
// with a per-byte watchdog that discards a byte the transmitter never completes.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned ADDR_W         = 4,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_en,
  input  logic [7:0]      wr_data,
  output logic            full,
  output logic            empty,
  output logic [ADDR_W:0] count,
  output logic            overflow,
  output logic            tx_load,
  output logic [7:0]      tx_byte,
  input  logic            tx_sent,
  output logic            tx_busy,
  output logic            tx_error
);

  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

  tx_state_t   state;
  tx_state_t   state_next;
  logic        pop;
  logic [7:0]  head;
  logic        tx_sent_q;
  logic        sent_rise;
  logic [15:0] wd_cnt;
  logic        wd_clr;
  logic        wd_inc;
  logic        err_next;

  sync_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (8)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow)
  );

  assign sent_rise = tx_sent & ~tx_sent_q;

  // Next-state and hand-off control; tx_load is decoded from LOAD, which
  // lasts exactly one cycle after the pop edge.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    wd_clr     = 1'b0;
    wd_inc     = 1'b0;
    err_next   = 1'b0;
    tx_load    = 1'b0;
    tx_busy    = 1'b1;
    case (state)
      IDLE: begin
        tx_busy = 1'b0;
        if (!empty) begin
          pop        = 1'b1;
          wd_clr     = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        tx_load    = 1'b1;
        wd_inc     = 1'b1;
        state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (sent_rise) begin
          state_next = IDLE;
        end else if (wd_cnt == WD_LAST) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end else begin
          wd_inc = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Completion edge detector history.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_sent_q <= 1'b0;
    end else begin
      tx_sent_q <= tx_sent;
    end
  end

  // Output byte holds from the pop until the next pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_byte <= 8'h00;
    end else if (pop) begin
      tx_byte <= head;
    end
  end

  // Watchdog counter and error pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt   <= '0;
      tx_error <= 1'b0;
    end else begin
      tx_error <= err_next;
      if (wd_clr) begin
        wd_cnt <= '0;
      end else if (wd_inc) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed self-checking bench for uart_tx_feeder.
module tb_uart_tx_feeder;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       tx_sent;

  logic       full, empty, overflow, tx_load, tx_busy, tx_error;
  logic [4:0] count;
  logic [7:0] tx_byte;

  logic       w_full, w_empty, w_overflow, w_load, w_busy, w_error;
  logic [4:0] w_count;
  logic [7:0] w_byte;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_feeder dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .tx_load  (tx_load),
    .tx_byte  (tx_byte),
    .tx_sent  (tx_sent),
    .tx_busy  (tx_busy),
    .tx_error (tx_error)
  );

  uart_tx_feeder #(.TIMEOUT_CYCLES(50)) dut_wd (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (w_full),
    .empty    (w_empty),
    .count    (w_count),
    .overflow (w_overflow),
    .tx_load  (w_load),
    .tx_byte  (w_byte),
    .tx_sent  (tx_sent),
    .tx_busy  (w_busy),
    .tx_error (w_error)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; tx_sent = 1'b0;
    step(); step();
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_load", tx_load, 0);
    chk("rst_byte", tx_byte, 8'h00);
    chk("rst_busy", tx_busy, 0);
    chk("rst_error", tx_error, 0);
    reset = 1'b0;
    step(); step();

    // single byte
    wr_en = 1'b1; wr_data = 8'h48; step();
    chk("s_empty_fall", empty, 0);
    chk("s_count1", count, 1);
    chk("s_noload", tx_load, 0);
    wr_en = 1'b0; step();
    chk("s_load", tx_load, 1);
    chk("s_byte", tx_byte, 8'h48);
    chk("s_empty_pop", empty, 1);
    chk("s_busy", tx_busy, 1);
    step();
    chk("s_load_low", tx_load, 0);
    chk("s_byte_hold", tx_byte, 8'h48);
    repeat (97) step();
    chk("s_busy_wait", tx_busy, 1);
    tx_sent = 1'b1; step();
    chk("s_done_busy", tx_busy, 0);
    chk("s_done_empty", empty, 1);
    chk("s_done_load", tx_load, 0);
    tx_sent = 1'b0; step();
    chk("s_idle_stay", tx_busy, 0);

    // burst "Hi!"
    wr_en = 1'b1; wr_data = 8'h48; step();
    wr_data = 8'h69; step();
    chk("b_load0", tx_load, 1);
    chk("b_byte0", tx_byte, 8'h48);
    wr_data = 8'h21; step();
    chk("b_load0_low", tx_load, 0);
    chk("b_count2", count, 2);
    wr_en = 1'b0;
    repeat (20) step();
    chk("b_byte0_hold", tx_byte, 8'h48);
    tx_sent = 1'b1; step();
    chk("b_idle0", tx_busy, 0);
    chk("b_byte0_keep", tx_byte, 8'h48);
    tx_sent = 1'b0; step();
    chk("b_load1", tx_load, 1);
    chk("b_byte1", tx_byte, 8'h69);
    chk("b_count1", count, 1);
    step();
    chk("b_load1_low", tx_load, 0);
    repeat (20) step();
    chk("b_byte1_hold", tx_byte, 8'h69);
    tx_sent = 1'b1; step();
    chk("b_idle1", tx_busy, 0);
    tx_sent = 1'b0; step();
    chk("b_load2", tx_load, 1);
    chk("b_byte2", tx_byte, 8'h21);
    chk("b_empty", empty, 1);
    repeat (6) step();
    tx_sent = 1'b1; step();
    chk("b_idle2", tx_busy, 0);
    tx_sent = 1'b0; step();

    // overflow
    wr_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_data = 8'(8'h10 + i);
      step();
    end
    chk("o_count15", count, 15);
    chk("o_notfull", full, 0);
    chk("o_noovf", overflow, 0);
    wr_data = 8'h20; step();
    chk("o_count16", count, 16);
    chk("o_full", full, 1);
    chk("o_noovf_fill", overflow, 0);
    for (int i = 0; i < 3; i++) begin
      wr_data = 8'hEE; step();
      chk("o_ovf", overflow, 1);
      chk("o_cap", count, 16);
    end
    wr_en = 1'b0; step();
    chk("o_ovf_clear", overflow, 0);
    chk("o_count_keep", count, 16);
    chk("o_byte_first", tx_byte, 8'h10);
    tx_sent = 1'b1; step();
    chk("o_idle", tx_busy, 0);
    tx_sent = 1'b0; wr_en = 1'b1; wr_data = 8'hEE; step();
    chk("o_pushpop_ovf", overflow, 1);
    chk("o_pushpop_cnt", count, 15);
    chk("o_pushpop_load", tx_load, 1);
    chk("o_pushpop_byte", tx_byte, 8'h11);
    wr_en = 1'b0; step();
    chk("o_after_ovf", overflow, 0);
    reset = 1'b1; step();
    reset = 1'b0;
    chk("o_flush", count, 0);

    // stale completion
    tx_sent = 1'b1; step();
    wr_en = 1'b1; wr_data = 8'hA5; step();
    wr_en = 1'b0; step();
    chk("st_load", tx_load, 1);
    chk("st_byte", tx_byte, 8'hA5);
    repeat (10) step();
    chk("st_held", tx_busy, 1);
    tx_sent = 1'b0; step();
    chk("st_drop", tx_busy, 1);
    tx_sent = 1'b1; step();
    chk("st_rise", tx_busy, 0);
    tx_sent = 1'b0; step();

    // watchdog (second instance, 50-cycle timeout)
    reset = 1'b1; step();
    reset = 1'b0;
    wr_en = 1'b1; wr_data = 8'h31; step();
    wr_data = 8'h32; step();
    wr_en = 1'b0;
    chk("w_load", w_load, 1);
    chk("w_byte", w_byte, 8'h31);
    for (int j = 1; j < 50; j++) begin
      step();
      chk("w_quiet", w_error, 0);
    end
    chk("w_busy", w_busy, 1);
    step();
    chk("w_error", w_error, 1);
    chk("w_idle", w_busy, 0);
    chk("w_noload", w_load, 0);
    chk("main_no_error", tx_error, 0);
    step();
    chk("w_err_pulse", w_error, 0);
    chk("w_next_load", w_load, 1);
    chk("w_next_byte", w_byte, 8'h32);
    step();
    chk("w_err_once", w_error, 0);

    // reset during WAIT_DONE with 3 queued
    reset = 1'b1; step();
    reset = 1'b0;
    wr_en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      wr_data = 8'(i);
      step();
    end
    wr_en = 1'b0;
    step(); step();
    chk("r_count3", count, 3);
    chk("r_busy", tx_busy, 1);
    chk("r_byte", tx_byte, 8'h01);
    reset = 1'b1; step();
    chk("r_count0", count, 0);
    chk("r_empty", empty, 1);
    chk("r_load", tx_load, 0);
    chk("r_byte0", tx_byte, 8'h00);
    chk("r_idle", tx_busy, 0);
    chk("r_full", full, 0);
    reset = 1'b0; step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
